// File: rtl/irq_collector_pkg.sv
// Shared register offsets and limits for the interrupt collector.
package irq_collector_pkg;

    localparam logic [11:0] IrqPendingOffset  = 12'h000;
    localparam logic [11:0] IrqEnableOffset   = 12'h004;
    localparam logic [11:0] IrqClaimOffset    = 12'h008;
    localparam logic [11:0] IrqOverflowOffset = 12'h00C;

    localparam int IrqMaxSrc        = 31;
    localparam int IrqClaimValidBit = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over the active interrupt vector.
module irq_prio_enc #(
    parameter int NumSrc = 8
) (
    input  logic [NumSrc-1:0] active,
    output logic              valid_o,
    output logic [4:0]        id_o
);

    always_comb begin
        valid_o = |active;
        id_o    = '0;
        // Walk downward so the lowest set index is the last one written.
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_o = 5'(i);
            end
        end
    end

endmodule

// File: rtl/irq_collector.sv
// Memory-mapped interrupt collector: edge-detected sticky pending bits,
// enable mask, overflow tracking and an atomic claim register.
module irq_collector
    import irq_collector_pkg::*;
#(
    parameter int NumSrc = 8
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              device_req_i,
    input  logic [31:0]       device_addr_i,
    input  logic              device_we_i,
    input  logic [3:0]        device_be_i,
    input  logic [31:0]       device_wdata_i,
    output logic              device_rvalid_o,
    output logic [31:0]       device_rdata_o,
    input  logic [NumSrc-1:0] src_irq_i,
    output logic              irq_o
);

    logic [NumSrc-1:0] src_q, src_d;
    logic [NumSrc-1:0] pending_q, pending_d;
    logic [NumSrc-1:0] enable_q, enable_d;
    logic [NumSrc-1:0] overflow_q, overflow_d;
    logic              armed_q, armed_d;
    logic              irq_q, irq_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [NumSrc-1:0] active, rise, clr, claim_clr, wmask;
    logic              claim_valid;
    logic [4:0]        claim_id;
    logic [11:0]       offset;
    logic              rd_req, wr_req;

    logic unused_bus;
    assign unused_bus = ^{device_be_i, device_addr_i[31:12], device_wdata_i};

    assign offset = device_addr_i[11:0];
    assign rd_req = device_req_i & ~device_we_i;
    assign wr_req = device_req_i & device_we_i;
    assign wmask  = device_wdata_i[NumSrc-1:0];
    assign active = pending_q & enable_q;

    irq_prio_enc #(
        .NumSrc (NumSrc)
    ) u_prio_enc (
        .active  (active),
        .valid_o (claim_valid),
        .id_o    (claim_id)
    );

    always_comb begin
        src_d   = src_irq_i;
        armed_d = 1'b1;
        // armed_q masks the first cycle after reset so a level held through
        // reset release is not mistaken for a fresh edge.
        rise    = src_irq_i & ~src_q & {NumSrc{armed_q}};

        claim_clr = '0;
        if (rd_req && offset == IrqClaimOffset && claim_valid) begin
            claim_clr = NumSrc'(1) << claim_id;
        end

        clr = claim_clr;
        if (wr_req && offset == IrqPendingOffset) begin
            clr = clr | wmask;
        end

        pending_d  = (pending_q & ~clr) | rise;

        overflow_d = overflow_q;
        if (wr_req && offset == IrqOverflowOffset) begin
            overflow_d = overflow_d & ~wmask;
        end
        overflow_d = overflow_d | (rise & pending_q & ~clr);

        enable_d = enable_q;
        if (wr_req && offset == IrqEnableOffset) begin
            enable_d = wmask;
        end

        irq_d    = |active;
        rvalid_d = device_req_i;

        rdata_d = '0;
        if (rd_req) begin
            unique case (offset)
                IrqPendingOffset:  rdata_d = {{(32-NumSrc){1'b0}}, pending_q};
                IrqEnableOffset:   rdata_d = {{(32-NumSrc){1'b0}}, enable_q};
                IrqOverflowOffset: rdata_d = {{(32-NumSrc){1'b0}}, overflow_q};
                IrqClaimOffset: begin
                    if (claim_valid) begin
                        rdata_d[IrqClaimValidBit] = 1'b1;
                        rdata_d[4:0]              = claim_id;
                    end
                end
                default:           rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q      <= '0;
            pending_q  <= '0;
            enable_q   <= '0;
            overflow_q <= '0;
            armed_q    <= 1'b0;
            irq_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            src_q      <= src_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            overflow_q <= overflow_d;
            armed_q    <= armed_d;
            irq_q      <= irq_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign device_rvalid_o = rvalid_q;
    assign device_rdata_o  = rdata_q;
    assign irq_o           = irq_q;

endmodule
